cp0_exc_unit: RTL

- Parametrised coprocessor-0 and exception-commit unit, split out of the writeback stage so it can serve cores with a configurable number of pipeline stages and interrupt lines.
- Holds the BadVAddr, Count, Compare, Status, Cause and EPC registers.
- Arbitrates exceptions reported by N pipeline stages plus interrupts at commit, and produces the flush/redirect, EPC and read data for MFC0.
- Adds features the old in-WB logic lacked:
  - 2-flop interrupt synchroniser;
  - programmable Count divider;
  - exception vector output;
  - defined collision rules.

---
 rtl/cp0_exc_unit_if.sv | 35 +++
 rtl/cp0_exc_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if: commit-side bus between the writeback stage and the CP0/exception unit
interface cp0_exc_unit_if #(
    parameter int NUM_STAGES = 4,
    parameter int HW_INT_W   = 6
);
    logic                      commit_valid;
    logic [31:0]               commit_pc;
    logic                      commit_bd;
    logic [NUM_STAGES-1:0]     stage_exc;
    logic [5*NUM_STAGES-1:0]   stage_excode;
    logic [32*NUM_STAGES-1:0]  stage_badva;
    logic [HW_INT_W-1:0]       hw_int;
    logic                      mtc0_en;
    logic [7:0]                mfc0_addr;
    logic [7:0]                mtc0_addr;
    logic [31:0]               mtc0_wdata;
    logic                      eret;
    logic [31:0]               mfc0_rdata;
    logic                      exc_taken;
    logic [31:0]               exc_vector;
    logic [31:0]               epc_out;
    logic [7:0]                int_pending;

    modport master (
        output commit_valid, commit_pc, commit_bd, stage_exc, stage_excode, stage_badva,
               hw_int, mtc0_en, mfc0_addr, mtc0_addr, mtc0_wdata, eret,
        input  mfc0_rdata, exc_taken, exc_vector, epc_out, int_pending
    );

    modport slave (
        input  commit_valid, commit_pc, commit_bd, stage_exc, stage_excode, stage_badva,
               hw_int, mtc0_en, mfc0_addr, mtc0_addr, mtc0_wdata, eret,
        output mfc0_rdata, exc_taken, exc_vector, epc_out, int_pending
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 registers, interrupt/exception arbitration and commit-time redirect
module cp0_exc_unit #(
    parameter int NUM_STAGES = 4,
    parameter int HW_INT_W   = 6,
    parameter int COUNT_DIV  = 2,
    parameter int SYNC_INT   = 1
) (
    input  logic           clk,
    input  logic           resetn,
    cp0_exc_unit_if.slave  bus
);
    localparam logic [31:0] STATUS_RST   = 32'h1040_0004;
    localparam logic [31:0] STATUS_WMASK = 32'h1000_FF1F;
    localparam logic [3:0]  DIV_LAST     = 4'(COUNT_DIV - 1);
    localparam logic [7:0]  A_BADVA      = 8'h40;
    localparam logic [7:0]  A_COUNT      = 8'h48;
    localparam logic [7:0]  A_COMPARE    = 8'h58;
    localparam logic [7:0]  A_STATUS     = 8'h60;
    localparam logic [7:0]  A_CAUSE      = 8'h68;
    localparam logic [7:0]  A_EPC        = 8'h70;

    logic [HW_INT_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, ip_hw_q, ip_hw_d;
    logic [31:0] badva_q, badva_d, count_q, count_d, compare_q, compare_d;
    logic [31:0] status_q, status_d, epc_q, epc_d;
    logic        bd_q, bd_d, ti_q, ti_d, dc_q, dc_d, iv_q, iv_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [3:0]  div_q, div_d;
    logic [7:0]  ip;
    logic [4:0]  win_code;
    logic [31:0] win_badva;
    logic        int_req, wrap;

    // Build Cause.IP: software bits, latched hardware lines, timer folded into IP7
    always_comb begin
        ip = {6'b0, ip_sw_q};
        ip[HW_INT_W+1:2] = ip_hw_q;
        ip[7] = ip[7] | ti_q;
    end

    assign int_req = bus.commit_valid & (|(ip & status_q[15:8])) & status_q[0] & ~status_q[1] & ~status_q[2];
    assign wrap    = div_q == DIV_LAST;

    // Pick the winning cause: interrupt first, then the oldest reporting stage
    always_comb begin
        win_code  = 5'd0;
        win_badva = 32'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (bus.stage_exc[i]) begin
                win_code  = bus.stage_excode[5*i +: 5];
                win_badva = bus.stage_badva[32*i +: 32];
            end
        end
        if (int_req) begin
            win_code  = 5'd0;
            win_badva = 32'd0;
        end
    end

    // Next-state for all CP0 state; a taken exception flushes any same-cycle MTC0/ERET
    always_comb begin
        sync1_d   = bus.hw_int;
        sync2_d   = sync1_q;
        ip_hw_d   = SYNC_INT != 0 ? sync2_q : bus.hw_int;
        badva_d   = badva_q;
        count_d   = count_q;
        compare_d = compare_q;
        status_d  = status_q;
        epc_d     = epc_q;
        bd_d      = bd_q;
        dc_d      = dc_q;
        iv_d      = iv_q;
        ip_sw_d   = ip_sw_q;
        exc_d     = exc_q;
        div_d     = div_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (!dc_q) begin
            div_d   = wrap ? 4'd0 : div_q + 4'd1;
            count_d = wrap ? count_q + 32'd1 : count_q;
        end
        if (bus.exc_taken) begin
            exc_d       = win_code;
            status_d[1] = 1'b1;
            if (!status_q[1]) begin
                epc_d = bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc;
                bd_d  = bus.commit_bd;
            end
            if (win_code == 5'd4 || win_code == 5'd5) badva_d = win_badva;
        end else if (bus.commit_valid) begin
            if (bus.mtc0_en) begin
                case (bus.mtc0_addr)
                    A_COUNT: begin
                        count_d = bus.mtc0_wdata;
                        div_d   = 4'd0;
                    end
                    A_COMPARE: begin
                        compare_d = bus.mtc0_wdata;
                        ti_d      = 1'b0;
                    end
                    A_STATUS: status_d = (status_q & ~STATUS_WMASK) | (bus.mtc0_wdata & STATUS_WMASK);
                    A_CAUSE: begin
                        dc_d    = bus.mtc0_wdata[27];
                        iv_d    = bus.mtc0_wdata[23];
                        ip_sw_d = bus.mtc0_wdata[9:8];
                    end
                    A_EPC: epc_d = bus.mtc0_wdata;
                    default: ;
                endcase
            end
            if (bus.eret) begin
                if (status_q[2]) status_d[2] = 1'b0;
                else status_d[1] = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            ip_hw_q   <= '0;
            badva_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= STATUS_RST;
            epc_q     <= '0;
            bd_q      <= 1'b0;
            ti_q      <= 1'b0;
            dc_q      <= 1'b0;
            iv_q      <= 1'b0;
            ip_sw_q   <= '0;
            exc_q     <= 5'h1f;
            div_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            ip_hw_q   <= ip_hw_d;
            badva_q   <= badva_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            epc_q     <= epc_d;
            bd_q      <= bd_d;
            ti_q      <= ti_d;
            dc_q      <= dc_d;
            iv_q      <= iv_d;
            ip_sw_q   <= ip_sw_d;
            exc_q     <= exc_d;
            div_q     <= div_d;
        end
    end

    // Outputs: redirect decision, vector, EPC, pending mask and MFC0 read mux
    always_comb begin
        bus.exc_taken   = bus.commit_valid & (int_req | (|bus.stage_exc));
        bus.exc_vector  = status_q[22] ? 32'hBFC0_0380 : 32'h8000_0180;
        bus.epc_out     = epc_q;
        bus.int_pending = ip & status_q[15:8];
        case (bus.mfc0_addr)
            A_BADVA:   bus.mfc0_rdata = badva_q;
            A_COUNT:   bus.mfc0_rdata = count_q;
            A_COMPARE: bus.mfc0_rdata = compare_q;
            A_STATUS:  bus.mfc0_rdata = status_q;
            A_CAUSE:   bus.mfc0_rdata = {bd_q, ti_q, 2'b0, dc_q, 3'b0, iv_q, 7'b0, ip, 1'b0, exc_q, 2'b0};
            A_EPC:     bus.mfc0_rdata = epc_q;
            default:   bus.mfc0_rdata = 32'd0;
        endcase
    end
endmodule
